// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline
// MEM stage (port A, fixed priority) and the image loader/readback DMA
// (port B, protected by a starvation counter). One access is outstanding at
// a time; writes finish in their issue cycle, reads wait RD_LAT cycles for
// memory data and then deliver it through a registered one-cycle rvalid pulse.
module dmem_arbiter #(
    parameter int WORD_LEN   = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                a_req,
    input  logic                a_we,
    input  logic [WORD_LEN-1:0] a_addr,
    input  logic [WORD_LEN-1:0] a_wdata,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [WORD_LEN-1:0] a_rdata,
    output logic                a_stall,

    input  logic                b_req,
    input  logic                b_we,
    input  logic [WORD_LEN-1:0] b_addr,
    input  logic [WORD_LEN-1:0] b_wdata,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [WORD_LEN-1:0] b_rdata,

    output logic                mem_re,
    output logic                mem_we,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    state_t     state;
    owner_t     owner;
    logic [2:0] lat_cnt;
    logic [3:0] b_wait_cnt;

    logic       a_elig;
    logic       b_elig;
    logic       b_starved;
    logic       sel_a;
    logic       sel_b;
    logic       win_we;
    logic       issue;

    // Arbitration, issue muxing and stall: all decided in the issue cycle.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves one unassigned and no latch is inferred.
        a_elig    = 1'b0;
        b_elig    = 1'b0;
        b_starved = 1'b0;
        sel_a     = 1'b0;
        sel_b     = 1'b0;

        // Holding reset low or waiting on a read blocks any new issue; a port
        // whose read completes this cycle must not be re-granted on the same
        // still-held request.
        if (rst && (state == IDLE)) begin
            a_elig = a_req & ~a_rvalid;
            b_elig = b_req & ~b_rvalid;
        end

        b_starved = b_elig && (b_wait_cnt >= 4'(STARVE_MAX));
        sel_b     = b_starved || (b_elig && !a_elig);
        sel_a     = a_elig && !sel_b;
        issue     = sel_a || sel_b;

        // With no winner the A inputs are passed through on the address and
        // data buses; the enables stay low so memory ignores them.
        win_we    = sel_b ? b_we    : a_we;
        mem_addr  = sel_b ? b_addr  : a_addr;
        mem_wdata = sel_b ? b_wdata : a_wdata;
        mem_we    = issue &  win_we;
        mem_re    = issue & ~win_we;

        a_gnt     = sel_a;
        b_gnt     = sel_b;

        // A granted write needs no hold; a read holds the pipeline until the
        // cycle its data shows up.
        a_stall   = rst & a_req & ~(a_gnt & a_we) & ~a_rvalid;
    end

    // Access sequencing: launch reads, count out the memory latency, then
    // capture the data into the owning port and pulse its rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OWN_A;
            lat_cnt  <= 3'd0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of the order
            // the statements are written in.
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (issue && !win_we) begin
                        state   <= RD_WAIT;
                        lat_cnt <= 3'(RD_LAT);
                        owner   <= sel_b ? OWN_B : OWN_A;
                    end
                end

                RD_WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        state   <= IDLE;
                        lat_cnt <= 3'd0;
                        if (owner == OWN_B) begin
                            b_rdata  <= mem_rdata;
                            b_rvalid <= 1'b1;
                        end else begin
                            a_rdata  <= mem_rdata;
                            a_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts cycles B is kept waiting, saturating at
    // STARVE_MAX so B is pushed ahead of A once it reaches the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_wait_cnt <= 4'd0;
        end else if (b_req && !b_gnt) begin
            if (b_wait_cnt < 4'(STARVE_MAX)) begin
                b_wait_cnt <= b_wait_cnt + 4'd1;
            end
        end else begin
            b_wait_cnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter with two instances,
// RD_LAT=1 (u_dut1) and RD_LAT=3 (u_dut3), each with a small memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic clk;
    logic rst;

    // Instance with RD_LAT = 1
    logic        a_req, a_we, a_gnt, a_rvalid, a_stall;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        m_re, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    // Instance with RD_LAT = 3
    logic        a3_req, a3_we, a3_gnt, a3_rvalid, a3_stall;
    logic [31:0] a3_addr, a3_wdata, a3_rdata;
    logic        b3_req, b3_we, b3_gnt, b3_rvalid;
    logic [31:0] b3_addr, b3_wdata, b3_rdata;
    logic        m3_re, m3_we;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_arbiter #(.WORD_LEN(32), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_stall(a_stall),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_re(m_re), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata)
    );

    dmem_arbiter #(.WORD_LEN(32), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
        .a_gnt(a3_gnt), .a_rvalid(a3_rvalid), .a_rdata(a3_rdata), .a_stall(a3_stall),
        .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
        .b_gnt(b3_gnt), .b_rvalid(b3_rvalid), .b_rdata(b3_rdata),
        .mem_re(m3_re), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_rdata(m3_rdata)
    );

    // Memory models: word-indexed arrays, read data delayed by RD_LAT edges.
    logic [31:0] mem1 [0:255];
    logic [31:0] pipe1;
    logic [31:0] mem3 [0:255];
    logic [31:0] pipe3 [0:2];

    always @(posedge clk) begin
        if (m_we) mem1[m_addr[9:2]] <= m_wdata;
        pipe1 <= m_re ? mem1[m_addr[9:2]] : 32'h0;
    end
    assign m_rdata = pipe1;

    always @(posedge clk) begin
        if (m3_we) mem3[m3_addr[9:2]] <= m3_wdata;
        pipe3[0] <= m3_re ? mem3[m3_addr[9:2]] : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign m3_rdata = pipe3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    endtask

    logic [6:0] exp_ag;
    logic [6:0] exp_bg;

    initial begin
        rst = 1'b0;
        drive_a(1'b1, 1'b0, 32'h10, 32'h0);
        drive_b(1'b1, 1'b0, 32'h20, 32'h0);
        a3_req = 1'b0; a3_we = 1'b0; a3_addr = 32'h0; a3_wdata = 32'h0;
        b3_req = 1'b0; b3_we = 1'b0; b3_addr = 32'h0; b3_wdata = 32'h0;

        // Reset state, with requests active to show outputs are gated.
        #2;
        check("rst_a_gnt", {31'b0, a_gnt}, 32'd0);
        check("rst_b_gnt", {31'b0, b_gnt}, 32'd0);
        check("rst_mem_re", {31'b0, m_re}, 32'd0);
        check("rst_mem_we", {31'b0, m_we}, 32'd0);
        check("rst_a_stall", {31'b0, a_stall}, 32'd0);
        check("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        drive_a(1'b0, 1'b0, 32'h0, 32'h0);
        drive_b(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;

        // A write of 0x10 granted at once, no stall.
        step();
        drive_a(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        check("wr_a_gnt", {31'b0, a_gnt}, 32'd1);
        check("wr_mem_we", {31'b0, m_we}, 32'd1);
        check("wr_mem_re", {31'b0, m_re}, 32'd0);
        check("wr_mem_addr", m_addr, 32'h10);
        check("wr_mem_wdata", m_wdata, 32'hDEADBEEF);
        check("wr_a_stall", {31'b0, a_stall}, 32'd0);

        // A read of 0x10 held high: stall T and T+1, rvalid at T+2.
        step();
        drive_a(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check("rd_T_a_gnt", {31'b0, a_gnt}, 32'd1);
        check("rd_T_mem_re", {31'b0, m_re}, 32'd1);
        check("rd_T_a_stall", {31'b0, a_stall}, 32'd1);
        step();
        #1;
        check("rd_T1_a_gnt", {31'b0, a_gnt}, 32'd0);
        check("rd_T1_a_stall", {31'b0, a_stall}, 32'd1);
        check("rd_T1_a_rvalid", {31'b0, a_rvalid}, 32'd0);
        step();
        #1;
        check("rd_T2_a_rvalid", {31'b0, a_rvalid}, 32'd1);
        check("rd_T2_a_rdata", a_rdata, 32'hDEADBEEF);
        check("rd_T2_a_gnt", {31'b0, a_gnt}, 32'd0);
        check("rd_T2_a_stall", {31'b0, a_stall}, 32'd0);
        step();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rd_T3_a_rvalid", {31'b0, a_rvalid}, 32'd0);
        check("rd_T3_a_rdata_hold", a_rdata, 32'hDEADBEEF);

        // B write, then A write next cycle.
        step();
        drive_b(1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
        #1;
        check("bw_b_gnt", {31'b0, b_gnt}, 32'd1);
        check("bw_mem_we", {31'b0, m_we}, 32'd1);
        check("bw_mem_addr", m_addr, 32'h40);
        check("bw_mem_wdata", m_wdata, 32'hCAFEF00D);
        step();
        drive_b(1'b0, 1'b0, 32'h0, 32'h0);
        drive_a(1'b1, 1'b1, 32'h44, 32'h55AA55AA);
        #1;
        check("aw_a_gnt", {31'b0, a_gnt}, 32'd1);
        check("aw_b_gnt", {31'b0, b_gnt}, 32'd0);
        check("aw_mem_we", {31'b0, m_we}, 32'd1);
        check("aw_mem_addr", m_addr, 32'h44);

        // Starvation: A writes every cycle, B reads 0x40 and waits.
        // B wins once b_wait_cnt reaches 4 (cycle 4), read occupies cycle 5,
        // B's rvalid cycle 6 lets A win again.
        exp_ag = 7'b1001111;
        exp_bg = 7'b0010000;
        for (int i = 0; i < 7; i++) begin
            step();
            drive_a(1'b1, 1'b1, 32'h100 + 32'(i * 4), 32'(i));
            drive_b(1'b1, 1'b0, 32'h40, 32'h0);
            #1;
            check($sformatf("st%0d_a_gnt", i), {31'b0, a_gnt}, {31'b0, exp_ag[i]});
            check($sformatf("st%0d_b_gnt", i), {31'b0, b_gnt}, {31'b0, exp_bg[i]});
            if (i == 4) begin
                check("st4_mem_re", {31'b0, m_re}, 32'd1);
                check("st4_mem_addr", m_addr, 32'h40);
                check("st4_a_stall", {31'b0, a_stall}, 32'd1);
            end
            if (i == 6) begin
                check("st6_b_rvalid", {31'b0, b_rvalid}, 32'd1);
                check("st6_b_rdata", b_rdata, 32'hCAFEF00D);
            end
        end
        step();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0);
        drive_b(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("st7_b_rvalid", {31'b0, b_rvalid}, 32'd0);

        // RD_LAT=3 instance: B writes then reads 0x40; A arrives in RD_WAIT.
        step();
        b3_req = 1'b1; b3_we = 1'b1; b3_addr = 32'h40; b3_wdata = 32'h12345678;
        #1;
        check("l3_bw_gnt", {31'b0, b3_gnt}, 32'd1);
        check("l3_bw_mem_we", {31'b0, m3_we}, 32'd1);
        step();
        b3_we = 1'b0; b3_wdata = 32'h0;
        #1;
        check("l3_br_gnt", {31'b0, b3_gnt}, 32'd1);
        check("l3_br_mem_re", {31'b0, m3_re}, 32'd1);
        check("l3_br_mem_addr", m3_addr, 32'h40);
        for (int k = 1; k <= 3; k++) begin
            step();
            b3_req = 1'b0;
            a3_req = 1'b1; a3_we = 1'b1; a3_addr = 32'h200; a3_wdata = 32'h77;
            #1;
            check($sformatf("l3_T%0d_a_gnt", k), {31'b0, a3_gnt}, 32'd0);
            check($sformatf("l3_T%0d_b_rvalid", k), {31'b0, b3_rvalid}, 32'd0);
            check($sformatf("l3_T%0d_a_stall", k), {31'b0, a3_stall}, 32'd1);
        end
        step();
        #1;
        check("l3_T4_b_rvalid", {31'b0, b3_rvalid}, 32'd1);
        check("l3_T4_b_rdata", b3_rdata, 32'h12345678);
        check("l3_T4_a_gnt", {31'b0, a3_gnt}, 32'd1);
        step();
        a3_req = 1'b0;
        #1;
        check("l3_T5_b_rvalid", {31'b0, b3_rvalid}, 32'd0);

        // Reset mid RD_WAIT: outputs drop at once, the read is abandoned.
        step();
        drive_a(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check("rr_a_gnt", {31'b0, a_gnt}, 32'd1);
        step();
        #1;
        check("rr_wait_a_stall", {31'b0, a_stall}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rr_async_a_stall", {31'b0, a_stall}, 32'd0);
        check("rr_async_a_rdata", a_rdata, 32'd0);
        check("rr_async_a_gnt", {31'b0, a_gnt}, 32'd0);
        check("rr_async_mem_re", {31'b0, m_re}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rr_rel_a_rvalid", {31'b0, a_rvalid}, 32'd0);
        check("rr_rel_a_gnt", {31'b0, a_gnt}, 32'd1);
        check("rr_rel_mem_re", {31'b0, m_re}, 32'd1);
        step();
        #1;
        check("rr_rel1_a_rvalid", {31'b0, a_rvalid}, 32'd0);
        check("rr_rel1_a_gnt", {31'b0, a_gnt}, 32'd0);
        step();
        #1;
        check("rr_rel2_a_rvalid", {31'b0, a_rvalid}, 32'd1);
        check("rr_rel2_a_rdata", a_rdata, 32'hDEADBEEF);
        drive_a(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
